sisc_mem_arb: RTL and testbench

Sequences the SISC's single-ported unified memory and shares it between two requesters: the instruction-fetch path (IF, driven by ctrl in fetch) and the load/store path (LS, driven by ctrl in mem for LOD/STR/SWP). The block arbitrates round-robin, latches the winner's address, data and direction, and drives the memory for a fixed number of wait cycles. It then returns read data with a one-cycle acknowledge. It sits between ctrl/datapath and the memory model.

---
 rtl/sisc_pkg.sv | 17 +
 rtl/rr_arb2.sv | 18 +
 rtl/sisc_mem_arb.sv | 93 +++++++++
 tb/tb_sisc_mem_arb.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared types for the SISC unified-memory arbiter: FSM states, requester ids
// and default bus widths.
package sisc_pkg;
  localparam int AW_DEF = 16;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } gnt_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick between fetch and load/store. Purely combinational;
// the caller owns last_gnt.
module rr_arb2
  import sisc_pkg::*;
(
  input  logic if_req,
  input  logic ls_req,
  input  gnt_e last_gnt,
  output gnt_e gnt,
  output logic gnt_vld
);
  always_comb begin
    gnt_vld = if_req | ls_req;
    gnt     = GNT_IF;
    // LS wins when alone, or on a conflict when IF had the last turn
    if (ls_req && (!if_req || last_gnt == GNT_IF)) gnt = GNT_LS;
  end
endmodule

// File: rtl/sisc_mem_arb.sv
// Single-port memory sequencer shared by instruction fetch and load/store:
// round-robin grant, MEM_LAT-cycle access, one-cycle ack with registered rdata.
module sisc_mem_arb
  import sisc_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_ack,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  localparam int CW = 4;

  state_e        state, state_nxt;
  gnt_e          last_gnt, gnt;
  logic          gnt_vld;
  logic          we_q;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;

  rr_arb2 u_arb (
    .if_req   (if_req),
    .ls_req   (ls_req),
    .last_gnt (last_gnt),
    .gnt      (gnt),
    .gnt_vld  (gnt_vld)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Winner's request is frozen at grant; the loser's inputs are ignored until IDLE.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      last_gnt <= GNT_LS;
      we_q     <= 1'b0;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else if (state == IDLE && gnt_vld) begin
      last_gnt <= gnt;
      addr_q   <= (gnt == GNT_LS) ? ls_addr : if_addr;
      we_q     <= (gnt == GNT_LS) && ls_we;
      if (gnt == GNT_LS) wdata_q <= ls_wdata;
      cnt      <= CW'(MEM_LAT - 1);
    end else if (state == ACCESS) begin
      if (cnt != '0)  cnt     <= cnt - 1'b1;
      else if (!we_q) rdata_q <= mem_rdata;
    end
  end

  always_comb begin
    mem_en = (state == ACCESS);
    mem_we = mem_en & we_q;
    if_ack = (state == DONE) && (last_gnt == GNT_IF);
    ls_ack = (state == DONE) && (last_gnt == GNT_LS);
    busy   = (state != IDLE);
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
endmodule

// File: tb/tb_sisc_mem_arb.sv
// Bench for sisc_mem_arb: transaction-level phase model checked every cycle,
// directed literal scenarios, randomized two-requester traffic, plus a MEM_LAT=1 build.
module tb_sisc_mem_arb;
  localparam int AW = 16, DW = 32, LAT = 2;

  logic clk = 1'b0, rst_f = 1'b0;
  always #5 clk = ~clk;

  logic          if_req, ls_req, ls_we;
  logic [AW-1:0] if_addr, ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          if_ack, ls_ack, mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;

  logic          ls_req1;
  logic [AW-1:0] ls_addr1;
  logic          if_ack1, ls_ack1, mem_en1, mem_we1, busy1;
  logic [AW-1:0] mem_addr1;
  logic [DW-1:0] rdata1, mem_wdata1, mem_rdata1;

  int n_cmp = 0, n_mis = 0;
  bit chk_on = 0;

  sisc_mem_arb #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_f(rst_f),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ack(ls_ack),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  sisc_mem_arb #(.AW(AW), .DW(DW), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst_f(rst_f),
    .if_req(1'b0), .if_addr('0), .if_ack(if_ack1),
    .ls_req(ls_req1), .ls_we(1'b0), .ls_addr(ls_addr1), .ls_wdata('0), .ls_ack(ls_ack1),
    .rdata(rdata1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
  );

  function automatic logic [DW-1:0] fn(input int i);
    return (i == 16) ? 32'h12345678 : (32'hA5A50000 | DW'(i));
  endfunction

  // Memory seen by the DUT: written from the DUT's own bus
  bit            bwr[64];
  logic [DW-1:0] bval[64];
  assign mem_rdata  = bwr[mem_addr[5:0]] ? bval[mem_addr[5:0]] : fn(int'(mem_addr[5:0]));
  assign mem_rdata1 = {16'hC0DE, mem_addr1};
  always @(posedge clk)
    if (mem_en && mem_we) begin
      bwr[mem_addr[5:0]]  <= 1'b1;
      bval[mem_addr[5:0]] <= mem_wdata;
    end

  // Reference: ph = 0 idle, 1..LAT memory cycles, LAT+1 ack cycle
  int            ph = 0;
  logic          m_last_ls, m_gnt_ls, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  bit            mwr[64];
  logic [DW-1:0] mval[64];

  function automatic bit ls_wins();
    return ls_req && !(if_req && m_last_ls);
  endfunction

  always @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      ph <= 0; m_last_ls <= 1'b1; m_gnt_ls <= 1'b0; m_we <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
    end else if (ph == 0) begin
      if (if_req || ls_req) begin
        m_gnt_ls  <= ls_wins();
        m_last_ls <= ls_wins();
        m_addr    <= ls_wins() ? ls_addr : if_addr;
        m_we      <= ls_wins() && ls_we;
        if (ls_wins()) m_wdata <= ls_wdata;
        ph <= 1;
      end
    end else if (ph <= LAT) begin
      if (ph == LAT) begin
        if (m_we) begin
          mwr[m_addr[5:0]]  <= 1'b1;
          mval[m_addr[5:0]] <= m_wdata;
        end else
          m_rdata <= mwr[m_addr[5:0]] ? mval[m_addr[5:0]] : fn(int'(m_addr[5:0]));
      end
      ph <= ph + 1;
    end else
      ph <= 0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_on) begin
    chk("busy",   busy,   ph != 0);
    chk("mem_en", mem_en, ph >= 1 && ph <= LAT);
    chk("mem_we", mem_we, ph >= 1 && ph <= LAT && m_we);
    chk("if_ack", if_ack, ph == LAT + 1 && !m_gnt_ls);
    chk("ls_ack", ls_ack, ph == LAT + 1 && m_gnt_ls);
    chk("rdata",  rdata,  m_rdata);
    if (ph >= 1 && ph <= LAT) chk("mem_addr", mem_addr, m_addr);
    if (ph >= 1 && ph <= LAT && m_we) chk("mem_wdata", mem_wdata, m_wdata);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    bit ifp, lsp;
    int n;
    logic [DW-1:0] b2b_exp [3];
    b2b_exp[0] = 32'hDEADBEEF; b2b_exp[1] = 32'hA5A50001; b2b_exp[2] = 32'hA5A50002;
    if_req = 0; ls_req = 0; ls_we = 0; if_addr = '0; ls_addr = '0; ls_wdata = '0;
    ls_req1 = 0; ls_addr1 = '0;
    step(); chk_on = 1; step();
    chk("rst_busy", busy, 0); chk("rst_mem_en", mem_en, 0); chk("rst_rdata", rdata, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_acks", {if_ack, ls_ack}, 0);
    rst_f = 1; step();

    // single fetch
    if_req = 1; if_addr = 16'h0010; step();
    chk("f_en1", mem_en, 1); chk("f_addr", mem_addr, 16'h0010); chk("f_we", mem_we, 0);
    step(); chk("f_en2", mem_en, 1);
    step(); chk("f_ack", if_ack, 1); chk("f_rdata", rdata, 32'h12345678); chk("f_en_off", mem_en, 0);
    if_req = 0;
    step(); chk("f_busy", busy, 0);

    // store
    ls_req = 1; ls_we = 1; ls_addr = 16'h0200; ls_wdata = 32'hDEADBEEF; step();
    chk("s_en", mem_en, 1); chk("s_we", mem_we, 1);
    chk("s_addr", mem_addr, 16'h0200); chk("s_wdata", mem_wdata, 32'hDEADBEEF);
    step(); chk("s_we2", mem_we, 1);
    step(); chk("s_ack", ls_ack, 1); chk("s_rdata_hold", rdata, 32'h12345678);
    ls_req = 0; ls_we = 0;
    step();

    // back-to-back fetches with req held high
    if_req = 1;
    for (int k = 0; k < 3; k++) begin
      if_addr = AW'(k); n = 0;
      do begin step(); n++; end while (!if_ack && n < 10);
      chk("b2b_gap", n, (k == 0) ? 3 : 4);
      chk("b2b_rdata", rdata, b2b_exp[k]);
    end
    if_req = 0; step();

    // randomized traffic
    ifp = 0; lsp = 0;
    for (int c = 0; c < 800; c++) begin
      step();
      if (if_ack) ifp = 0;
      if (ls_ack) lsp = 0;
      if (!ifp) begin
        if ($urandom_range(0, 3) != 0) begin
          if_req = 1; if_addr = AW'($urandom_range(0, 16'hFFFF)); ifp = 1;
        end else if_req = 0;
      end
      if (!lsp) begin
        if ($urandom_range(0, 2) != 0) begin
          ls_req = 1; ls_we = $urandom_range(0, 1) != 0;
          ls_addr = AW'($urandom_range(0, 16'hFFFF)); ls_wdata = $urandom; lsp = 1;
        end else ls_req = 0;
      end
    end
    if_req = 0; ls_req = 0;
    repeat (6) step();

    // reset in the first ACCESS cycle of a store
    ls_req = 1; ls_we = 1; ls_addr = 16'h0033; ls_wdata = 32'hCAFEF00D; step();
    #1 rst_f = 0; #1;
    chk("r_en", mem_en, 0); chk("r_we", mem_we, 0); chk("r_busy", busy, 0);
    if_req = 1; if_addr = 16'h0005;
    step(); chk("r_no_ack", ls_ack, 0);
    rst_f = 1;
    for (int c = 1; c <= 16; c++) begin
      step();
      chk("cf_if_ack", if_ack, c == 3 || c == 11);
      chk("cf_ls_ack", ls_ack, c == 7 || c == 15);
      if (c == 5) chk("cf_ls_we", mem_we, 1);
    end
    if_req = 0; ls_req = 0; ls_we = 0;
    repeat (6) step();

    // MEM_LAT=1 build, single load
    ls_req1 = 1; ls_addr1 = 16'h0042; step();
    chk("l1_en", mem_en1, 1); chk("l1_addr", mem_addr1, 16'h0042); chk("l1_we", mem_we1, 0);
    step();
    chk("l1_en_off", mem_en1, 0); chk("l1_ack", ls_ack1, 1); chk("l1_rdata", rdata1, 32'hC0DE0042);
    ls_req1 = 0;
    step(); chk("l1_ack_off", ls_ack1, 0); chk("l1_busy", busy1, 0); chk("l1_if_ack", if_ack1, 0);

    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
